regfile_wb_arbiter: RTL

Write-port controller for the 4-entry × 32-bit register file. It shares the file's single write port between two writeback requesters: ALU (A) and load/memory unit (M). Arbitration is round-robin with a valid/ready handshake, and the grant is registered onto the write-port signals. A pending-write scoreboard tells issue logic which registers have an outstanding write, and a saturating counter records contention stalls.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/rr_arbiter2.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
// Requester identities and the writeback request bundle live here.
package regfile_pkg;

  localparam int NUM_REGS = 4;
  localparam int REG_AW   = 2;
  localparam int DATA_W   = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational and one-hot;
// prio_q names the requester that wins the next tie.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_m,
  output logic gnt_a,
  output logic gnt_m
);

  req_e prio_q, prio_d;

  // Handshake: a transfer happens on a rising edge when req && gnt.
  // Grants are forced low while reset is asserted, whatever the requests.
  always_comb begin
    gnt_a  = 1'b0;
    gnt_m  = 1'b0;
    prio_d = prio_q;
    if (rst_n) begin
      if (req_a && (!req_m || prio_q == REQ_ALU)) begin
        gnt_a = 1'b1;
      end else if (req_m) begin
        gnt_m = 1'b1;
      end
    end
    if (gnt_a) begin
      prio_d = REQ_MEM;
    end else if (gnt_m) begin
      prio_d = REQ_ALU;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= REQ_ALU;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between ALU and memory
// writeback, tracks pending writes per register and counts contention.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int REG_AW = regfile_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [REG_AW-1:0]         a_reg,
  input  logic [DATA_W-1:0]         a_data,
  input  logic                      m_valid,
  output logic                      m_ready,
  input  logic [REG_AW-1:0]         m_reg,
  input  logic [DATA_W-1:0]         m_data,
  input  logic                      iss_valid,
  input  logic [REG_AW-1:0]         iss_reg,
  output logic                      rf_we,
  output logic [REG_AW-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [(1<<REG_AW)-1:0]    busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  localparam int NREG = 1 << REG_AW;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic a_gnt, m_gnt;

  logic              rf_we_q,    rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   busy_q,     busy_d;
  logic [CNT_W-1:0]  stall_q,    stall_d;
  logic [NREG-1:0]   set_v, clr_v;

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst_n (reset),
    .req_a (a_valid),
    .req_m (m_valid),
    .gnt_a (a_gnt),
    .gnt_m (m_gnt)
  );

  always_comb begin
    rf_we_d    = a_gnt | m_gnt;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (a_gnt) begin
      rf_waddr_d = a_reg;
      rf_wdata_d = a_data;
    end else if (m_gnt) begin
      rf_waddr_d = m_reg;
      rf_wdata_d = m_data;
    end

    // The clear tracks the write actually hitting the file, one edge after
    // acceptance; a reservation on the same edge wins over it.
    set_v = '0;
    clr_v = '0;
    if (iss_valid) set_v[iss_reg] = 1'b1;
    if (rf_we_q)   clr_v[rf_waddr_q] = 1'b1;
    busy_d = (busy_q & ~clr_v) | set_v;

    stall_d = stall_q;
    if (a_valid && m_valid && stall_q != CNT_MAX) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
      stall_q    <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
      stall_q    <= stall_d;
    end
  end

  assign a_ready   = a_gnt;
  assign m_ready   = m_gnt;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign busy      = busy_q;
  assign stall_cnt = stall_q;

endmodule
